lpif_txrx_x4_f2_master_link: RTL

- Master-side (D2D adapter end) logic-link bridge for the x4 full-rate Gen2 LPIF channel.
- Downstream: packs LPIF fields into a 77-bit flit, holds it in a 2-entry skid buffer, and pushes it into the logic-link TX FIFO under backpressure.
- Upstream: unpacks 77-bit flits from the logic-link RX FIFO into registered LPIF fields and flags protocol-state changes.
- Mirrors the slave-side bit layout exactly, so the two ends interoperate.

---
 rtl/lpif_x4_f2_pkg.sv | 48 ++++
 rtl/lpif_txrx_x4_f2_master_link_skid.sv | 60 ++++++
 rtl/lpif_txrx_x4_f2_master_link.sv | 110 +++++++++++
 3 files changed

// File: rtl/lpif_x4_f2_pkg.sv
// Shared flit layout, widths and LPIF state encodings for the x4 full-rate Gen2 logic link.
package lpif_x4_f2_pkg;

  localparam int unsigned STATE_LSB   = 0;
  localparam int unsigned PROTID_LSB  = 4;
  localparam int unsigned DATA_LSB    = 6;
  localparam int unsigned DVALID_BIT  = 70;
  localparam int unsigned CRC_LSB     = 71;
  localparam int unsigned CRCV_BIT    = 75;
  localparam int unsigned VALID_BIT   = 76;

  localparam int unsigned STATE_W     = PROTID_LSB - STATE_LSB;
  localparam int unsigned PROTID_W    = DATA_LSB - PROTID_LSB;
  localparam int unsigned DATA_W      = DVALID_BIT - DATA_LSB;
  localparam int unsigned CRC_W       = CRCV_BIT - CRC_LSB;
  localparam int unsigned FLIT_W      = VALID_BIT + 1;
  localparam int unsigned GEN1_DATA_W = 32;

  typedef enum logic [STATE_W-1:0] {
    LPIF_ST_NOP       = 4'h0,
    LPIF_ST_ACTIVE    = 4'h1,
    LPIF_ST_L1        = 4'h4,
    LPIF_ST_L2        = 4'h8,
    LPIF_ST_RESET     = 4'h9,
    LPIF_ST_LINKERROR = 4'hA,
    LPIF_ST_RETRAIN   = 4'hB,
    LPIF_ST_DISABLED  = 4'hC
  } lpif_state_e;

  // Field order mirrors the slave end, MSB first.
  typedef struct packed {
    logic                valid;
    logic                crc_valid;
    logic [CRC_W-1:0]    crc;
    logic                dvalid;
    logic [DATA_W-1:0]   data;
    logic [PROTID_W-1:0] protid;
    logic [STATE_W-1:0]  state;
  } lpif_flit_t;

  // Gen1 carries only the low data half; the upper half travels as zero.
  function automatic logic [DATA_W-1:0] lpif_mode_data(input logic [DATA_W-1:0] data,
                                                        input logic            gen2);
    lpif_mode_data = gen2 ? data
                          : {(DATA_W-GEN1_DATA_W)'(0), data[GEN1_DATA_W-1:0]};
  endfunction

endpackage

// File: rtl/lpif_txrx_x4_f2_master_link_skid.sv
// Generic 2-entry valid/ready skid buffer; head entry is presented whenever the buffer is non-empty.
module lpif_skid_buf2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_c,
  output logic [W-1:0] out_data_c,
  output logic         out_push_c,
  input  logic         out_full_i
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              accept_c;

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    cnt_d      = cnt_q;
    in_ready_c = !rst && (cnt_q < 2'd2);
    accept_c   = in_vld_i && in_ready_c;
    out_push_c = (cnt_q != 2'd0) && !out_full_i;
    out_data_c = (cnt_q != 2'd0) ? mem_q[head_q] : '0;

    if (accept_c) begin
      mem_d[tail_q] = in_data_i;
      tail_d        = ~tail_q;
    end
    if (out_push_c) begin
      head_d = ~head_q;
    end

    case ({accept_c, out_push_c})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/lpif_txrx_x4_f2_master_link.sv
// Master-side LPIF logic-link bridge: packs/skids downstream flits into the TX FIFO and
// registers unpacked upstream flits from the RX FIFO with a state-change pulse.
module lpif_txrx_x4_f2_master_link
  import lpif_x4_f2_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_gen2_mode,
  input  logic              user_downstream_vld,
  output logic              user_downstream_ready,
  input  logic [3:0]        dstrm_state,
  input  logic [1:0]        dstrm_protid,
  input  logic [63:0]       dstrm_data,
  input  logic              dstrm_dvalid,
  input  logic [3:0]        dstrm_crc,
  input  logic              dstrm_crc_valid,
  input  logic              dstrm_valid,
  output logic [FLIT_W-1:0] txfifo_downstream_data,
  output logic              txfifo_downstream_push,
  input  logic              txfifo_downstream_full,
  input  logic [FLIT_W-1:0] rxfifo_upstream_data,
  input  logic              rxfifo_upstream_vld,
  output logic [3:0]        ustrm_state,
  output logic [1:0]        ustrm_protid,
  output logic [63:0]       ustrm_data,
  output logic              ustrm_dvalid,
  output logic [3:0]        ustrm_crc,
  output logic              ustrm_crc_valid,
  output logic              ustrm_valid,
  output logic              ustrm_state_chg,
  output logic [CNT_W-1:0]  tx_flit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lpif_flit_t        dn_flit_c;
  lpif_flit_t        rx_flit_c;
  lpif_flit_t        ust_q, ust_d;
  logic              chg_q, chg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Downstream packing; mode is applied here so it is captured at accept time.
  always_comb begin
    dn_flit_c           = '0;
    dn_flit_c.state     = dstrm_state;
    dn_flit_c.protid    = dstrm_protid;
    dn_flit_c.data      = lpif_mode_data(dstrm_data, m_gen2_mode);
    dn_flit_c.dvalid    = dstrm_dvalid;
    dn_flit_c.crc       = dstrm_crc;
    dn_flit_c.crc_valid = dstrm_crc_valid;
    dn_flit_c.valid     = dstrm_valid;
  end

  lpif_skid_buf2 #(
    .W (FLIT_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_vld_i   (user_downstream_vld),
    .in_data_i  (dn_flit_c),
    .in_ready_c (user_downstream_ready),
    .out_data_c (txfifo_downstream_data),
    .out_push_c (txfifo_downstream_push),
    .out_full_i (txfifo_downstream_full)
  );

  // Upstream: qualifiers clear when idle, payload fields hold.
  always_comb begin
    rx_flit_c           = lpif_flit_t'(rxfifo_upstream_data);
    ust_d               = ust_q;
    ust_d.valid         = 1'b0;
    ust_d.dvalid        = 1'b0;
    ust_d.crc_valid     = 1'b0;
    chg_d               = 1'b0;
    cnt_d               = cnt_q;
    if (rxfifo_upstream_vld) begin
      ust_d      = rx_flit_c;
      ust_d.data = lpif_mode_data(rx_flit_c.data, m_gen2_mode);
      chg_d      = (rx_flit_c.state != ust_q.state);
    end
    if (txfifo_downstream_push && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ust_q <= '0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ust_q <= ust_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign ustrm_state     = ust_q.state;
  assign ustrm_protid    = ust_q.protid;
  assign ustrm_data      = ust_q.data;
  assign ustrm_dvalid    = ust_q.dvalid;
  assign ustrm_crc       = ust_q.crc;
  assign ustrm_crc_valid = ust_q.crc_valid;
  assign ustrm_valid     = ust_q.valid;
  assign ustrm_state_chg = chg_q;
  assign tx_flit_cnt     = cnt_q;

endmodule
